filter_capture_buffer: RTL and testbench
========================================

# filter_capture_buffer

Synthesizable sink at the output of `adaptive_filter`. It captures a block of `DEPTH` fixed-point samples from the filter's valid-only output stream, then drains them in arrival order over a valid/ready stream with a last-sample marker. It is used for on-chip capture and readback of filter responses, taking over the capture role that the simulation bench performs today.

## Interface
- `WORDLENGTH`, 14: total sample width in bits.
- `FRACTIONAL_LENGTH`, 6: fractional bits. Samples are indexed `[WORDLENGTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH]`; the block does not interpret them.
- `DEPTH`, 128: samples per capture. Must be a power of two and at least 2.

- `clk` in 1: single clock; everything is on its rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `start` in 1: arms a capture. Sampled only in IDLE.
- `s_tdata` in WORDLENGTH: sample from the filter.
- `s_tvalid` in 1: sample qualifier. There is no backpressure; a sample is accepted whenever it arrives in CAPTURE.
- `m_tdata` out WORDLENGTH: drained sample.
- `m_tvalid` out 1: drain data valid.
- `m_tready` in 1: downstream ready.
- `m_tlast` out 1: marks the `DEPTH`-th drained sample.
- `busy` out 1: high whenever the state is not IDLE.
- `dropped` out 1: sticky flag. Set if `s_tvalid`=1 while in DRAIN. Cleared by reset or by an accepted `start`.

## Operation
- Storage: `DEPTH` x `WORDLENGTH` memory, either synchronous-read RAM or registers. Write pointer and read pointer are each `$clog2(DEPTH)` bits wide.
- FSM states: IDLE, CAPTURE, DRAIN.
  - IDLE -> CAPTURE when `start`=1. The write pointer is set to 0 and `dropped` is cleared.
  - CAPTURE: each cycle with `s_tvalid`=1 writes `s_tdata` to mem[wr_ptr] and increments wr_ptr.
  - CAPTURE -> DRAIN on the cycle the `DEPTH`-th sample is written (wr_ptr = `DEPTH`-1 with `s_tvalid`=1). The pointer wraps to 0.
  - DRAIN: presents mem[0] through mem[`DEPTH`-1] in order. Each handshake (`m_tvalid` && `m_tready`) advances to the next sample.
  - DRAIN -> IDLE on the handshake of the sample with `m_tlast`=1.
- `start` in CAPTURE or DRAIN is ignored; no re-arm and no restart.
- `s_tvalid` in IDLE: the sample is discarded silently and no flag is set.
- `s_tvalid` in DRAIN: the sample is discarded and `dropped` is set.
- Data is stored and returned bit-exact: no rounding, saturation or sign handling.
- Reset at any time: state goes to IDLE, pointers to 0, and every output to 0. Memory contents are don't-care. A capture or drain that was in progress is abandoned.

## Timing
- Reset values: `m_tdata`=0, `m_tvalid`=0, `m_tlast`=0, `busy`=0, `dropped`=0.
- `start` high in cycle t (IDLE): `busy`=1 from cycle t+1. Samples with `s_tvalid` in cycle t+1 or later are captured; the sample in cycle t is not.
- The `DEPTH`-th sample is accepted in cycle k. The state is DRAIN from k+1. `m_tvalid` rises in k+2 carrying mem[0].
- Drain throughput: one sample per cycle while `m_tready`=1, with no bubbles. A prefetch/skid register is required.
- While `m_tvalid`=1 and `m_tready`=0, `m_tdata` and `m_tlast` hold stable.
- `m_tvalid` never drops without a handshake.
- After the last handshake in cycle j: `m_tvalid`=0, `m_tlast`=0 and `busy`=0 from j+1. A `start` in j+1 is accepted.
- `m_tlast` is high only together with `m_tvalid` on the `DEPTH`-th sample.
- No combinational path from `m_tready` to `m_tvalid`. A combinational path from `m_tready` to the internal read-address advance is permitted.

## Test plan
- Basic capture: `start` pulse, then 128 consecutive samples (value i << 6) -> `busy` from the next cycle. `m_tvalid` 2 cycles after the 128th sample. Samples 0..127 drain in order with `m_tready`=1, one per cycle. `m_tlast` only on sample 127. `busy`=0 the next cycle.
- Gapped input: `s_tvalid` on alternate cycles -> exactly 128 samples captured, gaps not stored, drain order matches input order.
- Backpressure: random `m_tready` at 30% duty -> `m_tdata` stable during stalls, no duplicated or lost samples, `m_tlast` on the 128th handshake.
- Ignored events:
  - `s_tvalid` in IDLE -> not stored and `dropped` stays 0.
  - `start` mid-capture -> no restart.
  - `s_tvalid` during DRAIN -> `dropped`=1 until the next accepted `start` clears it.
- Reset mid-drain: `arst_n` low asynchronously after the 50th handshake -> all outputs 0 immediately. A fresh `start` and 128 new samples drain correctly, with no stale data from the first run.
- `DEPTH`=2 corner: `start`, samples A and B -> A then B drained, `m_tlast` on B, back in IDLE.

Source files
------------

// File: rtl/filter_capture_buffer.sv
// filter_capture_buffer: captures DEPTH samples from the filter output
// stream, then drains them in arrival order over valid/ready with tlast.
//
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset
//   start              arms a capture (only honoured in IDLE)
//   s_tdata, s_tvalid  filter sample stream, no backpressure
//   m_tdata, m_tvalid  drained sample stream
//   m_tready, m_tlast  downstream ready, marks the DEPTH-th sample
//   busy               high while capturing or draining
//   dropped            sticky: a sample arrived while draining
module filter_capture_buffer #(
    parameter int WORDLENGTH        = 14,
    parameter int FRACTIONAL_LENGTH = 6,
    parameter int DEPTH             = 128
) (
    input  logic clk,
    input  logic arst_n,
    input  logic start,
    input  logic [WORDLENGTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH] s_tdata,
    input  logic s_tvalid,
    output logic [WORDLENGTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH] m_tdata,
    output logic m_tvalid,
    input  logic m_tready,
    output logic m_tlast,
    output logic busy,
    output logic dropped
);

    localparam int MSB = WORDLENGTH - FRACTIONAL_LENGTH - 1;
    localparam int LSB = -FRACTIONAL_LENGTH;
    localparam int AW  = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [MSB:LSB] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          loaded_all;
    logic          arm;
    logic          wr_en;
    logic          load;
    logic          hs;

    assign hs   = m_tvalid && m_tready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The output register is the prefetch stage: it refills from memory
    // whenever it is empty or being consumed, so a steady m_tready gives
    // one sample per cycle while m_tvalid itself stays a pure register.
    always_comb begin
        state_next = state;
        arm        = 1'b0;
        wr_en      = 1'b0;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    arm        = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                wr_en = s_tvalid;
                if (s_tvalid && wr_ptr == LAST_IDX) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                load = !loaded_all && (!m_tvalid || m_tready);
                if (hs && m_tlast) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sample storage carries no reset; its contents are only ever read
    // after a full capture has overwritten every location.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            loaded_all <= 1'b0;
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            if (arm) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                loaded_all <= 1'b0;
                dropped    <= 1'b0;
            end

            // Pointer wraps to 0 after the last write, ready for the next run.
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (state == DRAIN && s_tvalid) begin
                dropped <= 1'b1;
            end

            if (load) begin
                m_tdata  <= mem[rd_ptr];
                m_tvalid <= 1'b1;
                m_tlast  <= (rd_ptr == LAST_IDX);
                rd_ptr   <= rd_ptr + 1'b1;
                if (rd_ptr == LAST_IDX) begin
                    loaded_all <= 1'b1;
                end
            end else if (hs) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_filter_capture_buffer.sv
// tb_filter_capture_buffer: scenario table plus hand sequences for the
// capture buffer, checked against a queue-based reference model.
module tb_filter_capture_buffer;

    localparam int W = 14;
    localparam int F = 6;
    localparam int D = 128;

    typedef struct {
        bit ramp;
        bit gaps;
        int pct;
        bit mid_start;
        bit drop;
        bit idle_noise;
        int rst_after;
        bit exp_dropped;
    } vec_t;

    logic clk = 1'b0;
    logic arst_n;
    logic start, s_tvalid, m_tready;
    logic m_tvalid, m_tlast, busy, dropped;
    logic [W-1:0] s_tdata, m_tdata;

    logic start2, s_tvalid2, m_tready2;
    logic m_tvalid2, m_tlast2, busy2, dropped2;
    logic [W-1:0] s_tdata2, m_tdata2;

    logic [W-1:0] exp_q[$];
    bit mdl_dropped = 1'b0;
    int checks = 0;
    int errors = 0;

    vec_t tbl[7];

    always #5 clk = ~clk;

    filter_capture_buffer #(
        .WORDLENGTH(W), .FRACTIONAL_LENGTH(F), .DEPTH(D)
    ) u_dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .busy(busy), .dropped(dropped)
    );

    filter_capture_buffer #(
        .WORDLENGTH(W), .FRACTIONAL_LENGTH(F), .DEPTH(2)
    ) u_d2 (
        .clk(clk), .arst_n(arst_n), .start(start2),
        .s_tdata(s_tdata2), .s_tvalid(s_tvalid2),
        .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tready(m_tready2),
        .m_tlast(m_tlast2), .busy(busy2), .dropped(dropped2)
    );

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input vec_t v);
        int n;
        int cyc;
        bit on;
        n = 0;
        cyc = 0;
        exp_q.delete();
        if (v.idle_noise) begin
            for (int i = 0; i < 4; i++) begin
                s_tvalid = 1'b1;
                s_tdata = W'($urandom);
                tick();
            end
            chk("idle_busy", 32'(busy), 0);
            chk("idle_dropped", 32'(dropped), 32'(mdl_dropped));
            chk("idle_tvalid", 32'(m_tvalid), 0);
        end
        // The sample in the start cycle itself must not be stored.
        start = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = W'($urandom);
        tick();
        start = 1'b0;
        mdl_dropped = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("dropped_cleared", 32'(dropped), 0);
        while (n < D) begin
            on = v.gaps ? (cyc % 2 == 1) : 1'b1;
            s_tvalid = on;
            s_tdata = v.ramp ? W'(n << 6) : W'($urandom);
            start = v.mid_start && (n == D / 2);
            if (on) begin
                exp_q.push_back(s_tdata);
                n++;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        s_tvalid = 1'b0;
        chk("k1_tvalid", 32'(m_tvalid), 0);
        chk("k1_busy", 32'(busy), 1);
        tick();
        chk("k2_tvalid", 32'(m_tvalid), 1);
        chk("k2_first", 32'(m_tdata), 32'(exp_q[0]));
    endtask

    task automatic drain(input int pct, input bit drop, input int limit);
        int got;
        int guard;
        bit stalled;
        logic [W-1:0] hold_d;
        logic hold_l;
        got = 0;
        guard = 0;
        stalled = 1'b0;
        hold_d = '0;
        hold_l = 1'b0;
        while (got < limit && guard < 5000) begin
            m_tready = ($urandom_range(0, 99) < pct);
            s_tvalid = drop && (got == 10);
            s_tdata = W'($urandom);
            if (s_tvalid) mdl_dropped = 1'b1;
            chk("drain_tvalid", 32'(m_tvalid), 1);
            if (stalled) begin
                chk("stall_data", 32'(m_tdata), 32'(hold_d));
                chk("stall_last", 32'(m_tlast), 32'(hold_l));
            end
            if (m_tready) begin
                chk("drain_data", 32'(m_tdata), 32'(exp_q[got]));
                chk("drain_last", 32'(m_tlast), 32'(got == D - 1));
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hold_d = m_tdata;
                hold_l = m_tlast;
            end
            tick();
            guard++;
        end
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        chk("drain_count", got, limit);
    endtask

    initial begin
        //          ramp  gaps  pct  mid   drop  noise rst exp_drop
        tbl[0] = '{1'b1, 1'b0, 100, 1'b0, 1'b0, 1'b1, 0,  1'b0};
        tbl[1] = '{1'b0, 1'b1, 100, 1'b0, 1'b0, 1'b1, 0,  1'b0};
        tbl[2] = '{1'b0, 1'b0, 30,  1'b0, 1'b0, 1'b0, 0,  1'b0};
        tbl[3] = '{1'b0, 1'b0, 100, 1'b1, 1'b1, 1'b0, 0,  1'b1};
        tbl[4] = '{1'b0, 1'b1, 30,  1'b1, 1'b0, 1'b1, 0,  1'b0};
        tbl[5] = '{1'b0, 1'b0, 100, 1'b0, 1'b1, 1'b0, 50, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 100, 1'b0, 1'b0, 1'b1, 0,  1'b0};

        arst_n = 1'b1;
        start = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
        start2 = 1'b0; s_tvalid2 = 1'b0; s_tdata2 = '0; m_tready2 = 1'b0;
        #1 arst_n = 1'b0;
        #2;
        chk("rst_tdata", 32'(m_tdata), 0);
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tlast", 32'(m_tlast), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dropped", 32'(dropped), 0);
        chk("rst2_busy", 32'(busy2), 0);
        #10 arst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            capture(tbl[i]);
            if (tbl[i].rst_after > 0) begin
                drain(tbl[i].pct, tbl[i].drop, tbl[i].rst_after);
                chk("pre_rst_dropped", 32'(dropped), 32'(tbl[i].exp_dropped));
                #1 arst_n = 1'b0;
                #1;
                chk("arst_tdata", 32'(m_tdata), 0);
                chk("arst_tvalid", 32'(m_tvalid), 0);
                chk("arst_tlast", 32'(m_tlast), 0);
                chk("arst_busy", 32'(busy), 0);
                chk("arst_dropped", 32'(dropped), 0);
                #1 arst_n = 1'b1;
                mdl_dropped = 1'b0;
                tick();
            end else begin
                drain(tbl[i].pct, tbl[i].drop, D);
                chk("end_tvalid", 32'(m_tvalid), 0);
                chk("end_tlast", 32'(m_tlast), 0);
                chk("end_busy", 32'(busy), 0);
                chk("end_dropped", 32'(dropped), 32'(tbl[i].exp_dropped));
            end
        end

        // DEPTH=2 corner: A then B, tlast on B, back to IDLE.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("d2_busy", 32'(busy2), 1);
        s_tvalid2 = 1'b1;
        s_tdata2 = 14'h1abc;
        tick();
        s_tdata2 = 14'h0123;
        tick();
        s_tvalid2 = 1'b0;
        chk("d2_k1_tvalid", 32'(m_tvalid2), 0);
        chk("d2_k1_busy", 32'(busy2), 1);
        m_tready2 = 1'b1;
        tick();
        chk("d2_a_tvalid", 32'(m_tvalid2), 1);
        chk("d2_a_data", 32'(m_tdata2), 32'h1abc);
        chk("d2_a_last", 32'(m_tlast2), 0);
        tick();
        chk("d2_b_tvalid", 32'(m_tvalid2), 1);
        chk("d2_b_data", 32'(m_tdata2), 32'h0123);
        chk("d2_b_last", 32'(m_tlast2), 1);
        tick();
        m_tready2 = 1'b0;
        chk("d2_end_tvalid", 32'(m_tvalid2), 0);
        chk("d2_end_tlast", 32'(m_tlast2), 0);
        chk("d2_end_busy", 32'(busy2), 0);
        chk("d2_dropped", 32'(dropped2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
